exec_alu_branch_unit: RTL and testbench



---
 rtl/exec_alu_branch_unit_if.sv | 31 +++
 rtl/exec_alu_branch_unit.sv | 181 ++++++++++++++++++
 tb/tb_exec_alu_branch_unit.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_alu_branch_unit_if.sv
// exec_alu_branch_unit_if
// Bundles the decode/execute operand, control and result signals of the
// ALU/branch unit. The master drives operands and controls, and the slave
// (the unit itself) returns the branch target, ALU result, HI/LO and the
// branch decision.

interface exec_alu_branch_unit_if;
  logic [31:0] pc_plus_4;
  logic [31:0] branch_imm;
  logic [31:0] pc_branch;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  alu_control;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [3:0]  bcu_control;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        branch;

  modport master (
    output pc_plus_4, branch_imm, src_a, src_b, alu_control, bcu_control, rd1, rd2,
    input  pc_branch, result, hi, lo, branch
  );

  modport slave (
    input  pc_plus_4, branch_imm, src_a, src_b, alu_control, bcu_control, rd1, rd2,
    output pc_branch, result, hi, lo, branch
  );
endinterface

// File: rtl/exec_alu_branch_unit.sv
// exec_alu_branch_unit
// Execute/decode arithmetic core of the 5-stage MIPS pipeline. It contains
// the branch-target adder, the 32-bit ALU with its HI/LO multiply/divide
// registers, and the branch comparison unit. HI/LO are the only state.
// Optional feature: define ALU_DIV_EN to build the single-cycle DIV/DIVU
// divider. Without it, codes 0x0F/0x10 act as unused codes and no divider
// logic is built.

module exec_alu_branch_unit (
  input logic                   clk,
  input logic                   rst,
  exec_alu_branch_unit_if.slave bus
);

  localparam logic [4:0] OpAnd   = 5'h00;
  localparam logic [4:0] OpOr    = 5'h01;
  localparam logic [4:0] OpAdd   = 5'h02;
  localparam logic [4:0] OpXor   = 5'h03;
  localparam logic [4:0] OpNor   = 5'h04;
  localparam logic [4:0] OpSub   = 5'h06;
  localparam logic [4:0] OpSlt   = 5'h07;
  localparam logic [4:0] OpSltu  = 5'h08;
  localparam logic [4:0] OpSll   = 5'h09;
  localparam logic [4:0] OpSrl   = 5'h0A;
  localparam logic [4:0] OpSra   = 5'h0B;
  localparam logic [4:0] OpLui   = 5'h0C;
  localparam logic [4:0] OpMult  = 5'h0D;
  localparam logic [4:0] OpMultu = 5'h0E;
`ifdef ALU_DIV_EN
  localparam logic [4:0] OpDiv   = 5'h0F;
  localparam logic [4:0] OpDivu  = 5'h10;
`endif

  localparam logic [3:0] BcuBeq  = 4'd0;
  localparam logic [3:0] BcuBne  = 4'd1;
  localparam logic [3:0] BcuBlez = 4'd2;
  localparam logic [3:0] BcuBgtz = 4'd3;
  localparam logic [3:0] BcuBltz = 4'd4;
  localparam logic [3:0] BcuBgez = 4'd5;

  logic [31:0] opA;
  logic [31:0] opB;
  logic [4:0]  shamt;
  logic [63:0] prodSigned;
  logic [63:0] prodUnsigned;
  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic [31:0] hiNext;
  logic [31:0] loNext;
  logic        hiLoWe;
  logic        rd1Neg;
  logic        rd1Zero;
  logic [1:0]  unusedImmBits;

  assign opA   = bus.src_a;
  assign opB   = bus.src_b;
  assign shamt = bus.src_a[4:0];

  // The offset is a word offset, so its top two bits fall off the shifted add.
  assign unusedImmBits = bus.branch_imm[31:30];
  assign bus.pc_branch = bus.pc_plus_4 + {bus.branch_imm[29:0], 2'b00};

  // Low 64 bits of the product of sign-extended operands is the signed product.
  assign prodSigned   = {{32{opA[31]}}, opA} * {{32{opB[31]}}, opB};
  assign prodUnsigned = {32'h0, opA} * {32'h0, opB};

`ifdef ALU_DIV_EN
  logic        divByZero;
  logic [31:0] divisorSafe;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] magQuot;
  logic [31:0] magRem;
  logic [31:0] sQuot;
  logic [31:0] sRem;
  logic [31:0] uQuot;
  logic [31:0] uRem;

  // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly to
  // 0x80000000 with remainder 0; a zero divisor is replaced by 1 only to keep
  // the divider defined, the write is suppressed anyway.
  always_comb begin
    divByZero   = (opB == 32'h0);
    divisorSafe = divByZero ? 32'd1 : opB;
    magA        = opA[31] ? (32'h0 - opA) : opA;
    magB        = divisorSafe[31] ? (32'h0 - divisorSafe) : divisorSafe;
    magQuot     = magA / magB;
    magRem      = magA % magB;
    sQuot       = (opA[31] ^ divisorSafe[31]) ? (32'h0 - magQuot) : magQuot;
    sRem        = opA[31] ? (32'h0 - magRem) : magRem;
    uQuot       = opA / divisorSafe;
    uRem        = opA % divisorSafe;
  end
`endif

  // Decide whether this cycle's op writes HI/LO and with what.
  always_comb begin
    hiLoWe = 1'b0;
    hiNext = hiReg;
    loNext = loReg;
    case (bus.alu_control)
      OpMult: begin
        hiLoWe = 1'b1;
        hiNext = prodSigned[63:32];
        loNext = prodSigned[31:0];
      end
      OpMultu: begin
        hiLoWe = 1'b1;
        hiNext = prodUnsigned[63:32];
        loNext = prodUnsigned[31:0];
      end
`ifdef ALU_DIV_EN
      OpDiv: begin
        hiLoWe = !divByZero;
        hiNext = sRem;
        loNext = sQuot;
      end
      OpDivu: begin
        hiLoWe = !divByZero;
        hiNext = uRem;
        loNext = uQuot;
      end
`endif
      default: begin
        hiLoWe = 1'b0;
      end
    endcase
  end

  // ALU result; mult/div and unused codes return zero.
  always_comb begin
    bus.result = 32'h0;
    case (bus.alu_control)
      OpAnd:   bus.result = opA & opB;
      OpOr:    bus.result = opA | opB;
      OpAdd:   bus.result = opA + opB;
      OpXor:   bus.result = opA ^ opB;
      OpNor:   bus.result = ~(opA | opB);
      OpSub:   bus.result = opA - opB;
      OpSlt:   bus.result = {31'h0, ($signed(opA) < $signed(opB))};
      OpSltu:  bus.result = {31'h0, (opA < opB)};
      OpSll:   bus.result = opB << shamt;
      OpSrl:   bus.result = opB >> shamt;
      OpSra:   bus.result = $unsigned($signed(opB) >>> shamt);
      OpLui:   bus.result = {opB[15:0], 16'h0};
      default: bus.result = 32'h0;
    endcase
  end

  assign rd1Neg  = bus.rd1[31];
  assign rd1Zero = (bus.rd1 == 32'h0);

  // Branch condition evaluation; the caller qualifies it with its branch enable.
  always_comb begin
    bus.branch = 1'b0;
    case (bus.bcu_control)
      BcuBeq:  bus.branch = (bus.rd1 == bus.rd2);
      BcuBne:  bus.branch = (bus.rd1 != bus.rd2);
      BcuBlez: bus.branch = rd1Neg | rd1Zero;
      BcuBgtz: bus.branch = !rd1Neg && !rd1Zero;
      BcuBltz: bus.branch = rd1Neg;
      BcuBgez: bus.branch = !rd1Neg;
      default: bus.branch = 1'b0;
    endcase
  end

  // HI/LO registers: reset clears them at once and overrides any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hiReg <= 32'h0;
      loReg <= 32'h0;
    end else if (hiLoWe) begin
      hiReg <= hiNext;
      loReg <= loNext;
    end
  end

  assign bus.hi = hiReg;
  assign bus.lo = loReg;

endmodule

// File: tb/tb_exec_alu_branch_unit.sv
// tb_exec_alu_branch_unit
// Directed and randomized checks of exec_alu_branch_unit against an
// arithmetic reference model. Define ALU_DIV_EN here too when the design is
// built with the divider.

module tb_exec_alu_branch_unit;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;
  logic [31:0] modelHi;
  logic [31:0] modelLo;
  logic [31:0] savedHi;
  logic [31:0] savedLo;

  exec_alu_branch_unit_if bus ();

  exec_alu_branch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelPcBranch(input logic [31:0] pc, input logic [31:0] imm);
    logic [31:0] t;
    t = pc + imm * 32'd4;
    return t;
  endfunction

  function automatic logic [31:0] modelResult(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    int unsigned n;
    logic [31:0] r;
    sa = a;
    sb = b;
    n  = a % 32;
    r  = 32'h0;
    case (op)
      5'h00: r = a & b;
      5'h01: r = a | b;
      5'h02: r = a + b;
      5'h03: r = a ^ b;
      5'h04: r = ~(a | b);
      5'h06: r = a - b;
      5'h07: r = (sa < sb) ? 32'd1 : 32'd0;
      5'h08: r = (a < b) ? 32'd1 : 32'd0;
      5'h09: r = b << n;
      5'h0A: r = b >> n;
      5'h0B: r = sb >>> n;
      5'h0C: r = b * 32'd65536;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic modelBranch(input logic [3:0] code, input logic [31:0] r1, input logic [31:0] r2);
    int s1;
    s1 = r1;
    case (code)
      4'd0: return r1 == r2;
      4'd1: return r1 != r2;
      4'd2: return s1 <= 0;
      4'd3: return s1 > 0;
      4'd4: return s1 < 0;
      4'd5: return s1 >= 0;
      default: return 1'b0;
    endcase
  endfunction

  // Updates the HI/LO model as a clock edge would, using the presented inputs.
  task automatic modelEdge();
    longint          sa;
    longint          sb;
    longint          ps;
    longint          q;
    longint          r;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned pu;
    int              ia;
    int              ib;
    ia = bus.src_a;
    ib = bus.src_b;
    sa = ia;
    sb = ib;
    ua = 64'(bus.src_a);
    ub = 64'(bus.src_b);
    if (rst) begin
      modelHi = 32'h0;
      modelLo = 32'h0;
    end else begin
      case (bus.alu_control)
        5'h0D: begin
          ps = sa * sb;
          modelHi = ps[63:32];
          modelLo = ps[31:0];
        end
        5'h0E: begin
          pu = ua * ub;
          modelHi = pu[63:32];
          modelLo = pu[31:0];
        end
`ifdef ALU_DIV_EN
        5'h0F: if (sb != 0) begin
          q = sa / sb;
          r = sa % sb;
          modelHi = r[31:0];
          modelLo = q[31:0];
        end
        5'h10: if (ub != 0) begin
          pu = ua / ub;
          modelLo = pu[31:0];
          pu = ua % ub;
          modelHi = pu[31:0];
        end
`endif
        default: begin
          q = 0;
          r = 0;
        end
      endcase
    end
  endtask

  // Drives all inputs and checks the combinational outputs against the model.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic [3:0] bcu, input logic [31:0] r1, input logic [31:0] r2);
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    bus.pc_plus_4   = pc;
    bus.branch_imm  = imm;
    bus.bcu_control = bcu;
    bus.rd1         = r1;
    bus.rd2         = r2;
    #1;
    checkOutput("pcBranch", bus.pc_branch, modelPcBranch(pc, imm));
    checkOutput("result", bus.result, modelResult(op, a, b));
    checkOutput("branch", {31'h0, bus.branch}, {31'h0, modelBranch(bcu, r1, r2)});
  endtask

  // Takes one clock edge and checks HI/LO, then returns at the next negedge.
  task automatic clockAndCheck();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("hi", bus.hi, modelHi);
    checkOutput("lo", bus.lo, modelLo);
    @(negedge clk);
  endtask

  function automatic logic [31:0] randOperand();
    logic [31:0] v;
    int          sel;
    int          s;
    sel = $urandom_range(0, 4);
    case (sel)
      0: v = $urandom;
      1: begin
        s = $urandom_range(0, 16);
        s = s - 8;
        v = s;
      end
      2: v = 32'h80000000;
      3: v = 32'hFFFFFFFF;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  initial begin
    assertCount = 0;
    failCount   = 0;
    modelHi     = 32'h0;
    modelLo     = 32'h0;
    rst         = 1'b1;
    bus.alu_control = 5'h0;
    bus.src_a       = 32'h0;
    bus.src_b       = 32'h0;
    bus.pc_plus_4   = 32'h0;
    bus.branch_imm  = 32'h0;
    bus.bcu_control = 4'd0;
    bus.rd1         = 32'h0;
    bus.rd2         = 32'h0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("resetHi", bus.hi, 32'h0);
    checkOutput("resetLo", bus.lo, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset released, starting directed checks");

    applyStimulus(5'h00, 0, 0, 32'h00400010, 32'hFFFFFFFE, 4'd0, 5, 5);
    checkOutput("pcBackward", bus.pc_branch, 32'h00400008);
    applyStimulus(5'h00, 0, 0, 32'h00400010, 32'h00000003, 4'd1, 5, 5);
    checkOutput("pcForward", bus.pc_branch, 32'h0040001C);
    checkOutput("bneEqual", {31'h0, bus.branch}, 32'h0);

    applyStimulus(5'h02, 32'h7FFFFFFF, 32'h1, 0, 0, 4'd0, 5, 5);
    checkOutput("addWrap", bus.result, 32'h80000000);
    checkOutput("beqEqual", {31'h0, bus.branch}, 32'h1);
    applyStimulus(5'h06, 32'h0, 32'h1, 0, 0, 4'd2, 0, 0);
    checkOutput("subWrap", bus.result, 32'hFFFFFFFF);
    checkOutput("blezZero", {31'h0, bus.branch}, 32'h1);
    applyStimulus(5'h07, 32'hFFFFFFFF, 32'h1, 0, 0, 4'd3, 0, 0);
    checkOutput("sltNeg", bus.result, 32'h1);
    checkOutput("bgtzZero", {31'h0, bus.branch}, 32'h0);
    applyStimulus(5'h08, 32'hFFFFFFFF, 32'h1, 0, 0, 4'd4, 32'h80000000, 0);
    checkOutput("sltuBig", bus.result, 32'h0);
    checkOutput("bltzMin", {31'h0, bus.branch}, 32'h1);
    applyStimulus(5'h0B, 32'h4, 32'h80000000, 0, 0, 4'd5, 0, 0);
    checkOutput("sraSign", bus.result, 32'hF8000000);
    checkOutput("bgezZero", {31'h0, bus.branch}, 32'h1);
    applyStimulus(5'h0C, 32'h0, 32'h00001234, 0, 0, 4'd9, 0, 0);
    checkOutput("lui", bus.result, 32'h12340000);
    checkOutput("bcuUnused", {31'h0, bus.branch}, 32'h0);

    applyStimulus(5'h0D, 32'hFFFFFFFD, 32'h5, 0, 0, 4'd0, 0, 0);
    checkOutput("multResult", bus.result, 32'h0);
    clockAndCheck();
    checkOutput("multHi", bus.hi, 32'hFFFFFFFF);
    checkOutput("multLo", bus.lo, 32'hFFFFFFF1);
    applyStimulus(5'h0E, 32'hFFFFFFFF, 32'h2, 0, 0, 4'd0, 0, 0);
    clockAndCheck();
    checkOutput("multuHi", bus.hi, 32'h1);
    checkOutput("multuLo", bus.lo, 32'hFFFFFFFE);

    applyStimulus(5'h00, 32'h1, 32'h1, 0, 0, 4'd0, 0, 0);
    clockAndCheck();
    checkOutput("bubbleHi", bus.hi, 32'h1);

`ifdef ALU_DIV_EN
    applyStimulus(5'h0F, 32'hFFFFFFF9, 32'h2, 0, 0, 4'd0, 0, 0);
    clockAndCheck();
    checkOutput("divLo", bus.lo, 32'hFFFFFFFD);
    checkOutput("divHi", bus.hi, 32'hFFFFFFFF);
    applyStimulus(5'h0F, 32'h12345678, 32'h0, 0, 0, 4'd0, 0, 0);
    clockAndCheck();
    checkOutput("divZeroLo", bus.lo, 32'hFFFFFFFD);
    checkOutput("divZeroHi", bus.hi, 32'hFFFFFFFF);
    applyStimulus(5'h0F, 32'h80000000, 32'hFFFFFFFF, 0, 0, 4'd0, 0, 0);
    clockAndCheck();
    checkOutput("divOvfLo", bus.lo, 32'h80000000);
    checkOutput("divOvfHi", bus.hi, 32'h0);
`else
    savedHi = bus.hi;
    savedLo = bus.lo;
    applyStimulus(5'h0F, 32'hFFFFFFF9, 32'h2, 0, 0, 4'd0, 0, 0);
    checkOutput("divOffResult", bus.result, 32'h0);
    clockAndCheck();
    checkOutput("divOffHi", bus.hi, savedHi);
    checkOutput("divOffLo", bus.lo, savedLo);
`endif

    $display("[TB] reset override check");
    applyStimulus(5'h0D, 32'h7, 32'h9, 0, 0, 4'd0, 0, 0);
    clockAndCheck();
    checkOutput("preResetLo", bus.lo, 32'd63);
    applyStimulus(5'h0D, 32'h3, 32'h3, 0, 0, 4'd0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstHi", bus.hi, 32'h0);
    checkOutput("asyncRstLo", bus.lo, 32'h0);
    clockAndCheck();
    checkOutput("rstOverrideLo", bus.lo, 32'h0);
    rst = 1'b0;

    $display("[TB] randomized checks");
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r1;
      logic [31:0] r2;
      r1 = randOperand();
      r2 = ($urandom_range(0, 3) == 0) ? r1 : randOperand();
      applyStimulus(5'($urandom_range(0, 20)), randOperand(), randOperand(),
                    $urandom, $urandom, 4'($urandom_range(0, 15)), r1, r2);
      clockAndCheck();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
